// File: rtl/pu_msp430_ram_loader.sv
// Streams bytes into RAM port B as little-endian words, then reads the region
// back and compares a 16-bit additive checksum of what was written and read.
module pu_msp430_ram_loader #(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                start,
  input  logic [ADDR_MSB:0]   base_addr,
  input  logic [ADDR_MSB+1:0] len,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_MSB:0]   ram_addrb,
  output logic                ram_cenb,
  output logic [15:0]         ram_dinb,
  output logic [1:0]          ram_wenb,
  input  logic [15:0]         ram_doutb,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                chk_ok,
  output logic [15:0]         chk_sum,
  output logic [2:0]          state_dbg
);

  // Byte stream: a byte moves on a rising edge where s_valid and s_ready are
  // both high; s_ready is asserted only while collecting bytes (LOAD).

  localparam int AW = ADDR_MSB + 1;
  localparam int CW = ADDR_MSB + 2;
  localparam int EW = ADDR_MSB + 3;
  localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    VERIFY = 3'd3,
    VWAIT  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t          state;
  logic [AW-1:0]   base_q;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   byte_cnt;
  logic [CW-1:0]   rd_cnt;
  logic [7:0]      lo_byte;
  logic [15:0]     wr_sum;
  logic [15:0]     rd_sum;
  logic            cap_valid;
  logic            cap_mask;

  logic [EW-1:0]   end_byte;
  logic [CW-1:0]   n_words;
  logic [CW-1:0]   byte_cnt_nxt;
  logic [AW-1:0]   wr_addr;
  logic [15:0]     rd_word;
  logic [15:0]     rd_sum_nxt;

  assign state_dbg = state;

  always_comb begin
    end_byte     = {1'b0, base_addr, 1'b0} + {1'b0, len};
    n_words      = {1'b0, len_q[CW-1:1]} + CW'(len_q[0]);
    byte_cnt_nxt = byte_cnt + CW'(1);
    wr_addr      = base_q + byte_cnt[CW-1:1];
    // The trailing word of an odd load only owns its low byte.
    rd_word      = cap_mask ? {8'h00, ram_doutb[7:0]} : ram_doutb;
    rd_sum_nxt   = rd_sum + rd_word;
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      rd_cnt    <= '0;
      lo_byte   <= '0;
      wr_sum    <= '0;
      rd_sum    <= '0;
      cap_valid <= 1'b0;
      cap_mask  <= 1'b0;
      s_ready   <= 1'b0;
      ram_addrb <= '0;
      ram_cenb  <= 1'b1;
      ram_dinb  <= '0;
      ram_wenb  <= 2'b11;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      chk_ok    <= 1'b0;
      chk_sum   <= '0;
    end else begin
      // Read data returns one cycle after each VERIFY request.
      cap_valid <= (state == VERIFY);
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (end_byte > MEM_BYTES) begin
              err     <= 1'b1;
              chk_ok  <= 1'b0;
              chk_sum <= '0;
              done    <= 1'b1;
              state   <= FIN;
            end else if (len == '0) begin
              err     <= 1'b0;
              chk_ok  <= 1'b1;
              chk_sum <= '0;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              base_q   <= base_addr;
              len_q    <= len;
              byte_cnt <= '0;
              wr_sum   <= '0;
              rd_sum   <= '0;
              err      <= 1'b0;
              chk_ok   <= 1'b0;
              chk_sum  <= '0;
              s_ready  <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            byte_cnt <= byte_cnt_nxt;
            if (byte_cnt[0]) begin
              ram_dinb  <= {s_data, lo_byte};
              ram_wenb  <= 2'b00;
              ram_cenb  <= 1'b0;
              ram_addrb <= wr_addr;
              s_ready   <= 1'b0;
              state     <= WRITE;
            end else if (byte_cnt_nxt == len_q) begin
              ram_dinb  <= {8'h00, s_data};
              ram_wenb  <= 2'b10;
              ram_cenb  <= 1'b0;
              ram_addrb <= wr_addr;
              s_ready   <= 1'b0;
              state     <= WRITE;
            end else begin
              lo_byte <= s_data;
            end
          end
        end
        WRITE: begin
          wr_sum   <= wr_sum + ram_dinb;
          ram_wenb <= 2'b11;
          if (byte_cnt == len_q) begin
            ram_addrb <= base_q;
            rd_cnt    <= CW'(1);
            state     <= VERIFY;
          end else begin
            ram_cenb <= 1'b1;
            s_ready  <= 1'b1;
            state    <= LOAD;
          end
        end
        VERIFY: begin
          if (cap_valid) rd_sum <= rd_sum_nxt;
          cap_mask <= (rd_cnt == n_words) && len_q[0];
          if (rd_cnt == n_words) begin
            ram_cenb <= 1'b1;
            state    <= VWAIT;
          end else begin
            ram_addrb <= ram_addrb + AW'(1);
            rd_cnt    <= rd_cnt + CW'(1);
          end
        end
        VWAIT: begin
          rd_sum  <= rd_sum_nxt;
          chk_sum <= wr_sum;
          chk_ok  <= (wr_sum == rd_sum_nxt);
          done    <= 1'b1;
          state   <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_msp430_ram_loader.sv
// Bench for pu_msp430_ram_loader: behavioural RAM, byte-level reference model
// of the expected RAM image, write sequence and checksums.
module tb_pu_msp430_ram_loader;

  localparam int ADDR_MSB = 6;
  localparam int MEM_SIZE = 256;
  localparam int NW = MEM_SIZE / 2;
  localparam int W = 25;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic [7:0]  len = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [6:0]  ram_addrb;
  logic        ram_cenb;
  logic [15:0] ram_dinb;
  logic [1:0]  ram_wenb;
  logic [15:0] ram_doutb = '0;
  logic        busy, done, err, chk_ok;
  logic [15:0] chk_sum;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  // clock / reset
  always #5 mclk = ~mclk;

  pu_msp430_ram_loader #(.ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .base_addr(base_addr),
    .len(len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_addrb(ram_addrb), .ram_cenb(ram_cenb), .ram_dinb(ram_dinb),
    .ram_wenb(ram_wenb), .ram_doutb(ram_doutb), .busy(busy), .done(done),
    .err(err), .chk_ok(chk_ok), .chk_sum(chk_sum), .state_dbg(state_dbg)
  );

  // RAM model with access monitor
  logic [15:0]  mem [NW];
  logic         fill = 1'b0;
  logic         corrupt_en = 1'b0;
  logic [6:0]   corrupt_addr = '0;
  int           acc_cnt = 0;
  logic [W-1:0] act_q[$];
  logic [7:0]   bytes_q[$];

  always @(posedge mclk) begin
    if (fill) begin
      for (int i = 0; i < NW; i++) mem[i] <= 16'($urandom);
    end else if (!ram_cenb) begin
      acc_cnt <= acc_cnt + 1;
      if (ram_wenb != 2'b11) act_q.push_back({ram_addrb, ram_wenb, ram_dinb});
      if (!ram_wenb[0]) mem[ram_addrb][7:0] <= ram_dinb[7:0];
      if (!ram_wenb[1]) mem[ram_addrb][15:8] <= ram_dinb[15:8];
      if (ram_wenb == 2'b11)
        ram_doutb <= mem[ram_addrb] ^
                     ((corrupt_en && ram_addrb == corrupt_addr) ? 16'h0001 : 16'h0000);
    end
  end

  // driver + scoreboard for one complete load
  task automatic run_load(input logic [6:0] b, input logic [7:0] l, input bit gaps,
                          input bit corrupt, input bit poke_start, input string tag);
    logic [15:0]  exp_mem [NW];
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_sum;
    logic [7:0]   hi;
    int nw, n0, a0, idx, cyc, bad;
    bit seen;
    nw = (int'(l) + 1) / 2;
    exp_sum = '0;
    for (int i = 0; i < NW; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < int'(l); i++) begin
      int wa;
      wa = (int'(b) + i / 2) % NW;
      if (i % 2 == 0) exp_mem[wa][7:0] = bytes_q[i];
      else exp_mem[wa][15:8] = bytes_q[i];
      exp_sum = exp_sum + ((i % 2 == 1) ? {bytes_q[i], 8'h00} : {8'h00, bytes_q[i]});
    end
    for (int w = 0; w < nw; w++) begin
      hi = (2 * w + 1 < int'(l)) ? bytes_q[2 * w + 1] : 8'h00;
      exp_q.push_back({7'(int'(b) + w), (2 * w + 1 < int'(l)) ? 2'b00 : 2'b10,
                       hi, bytes_q[2 * w]});
    end
    corrupt_addr = b;
    corrupt_en = corrupt;
    n0 = act_q.size();
    a0 = acc_cnt;
    @(negedge mclk);
    start = 1'b1; base_addr = b; len = l;
    @(negedge mclk);
    start = 1'b0;
    idx = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (done) begin
        seen = 1'b1;
        n_checks++;
        if (chk_sum !== exp_sum) begin
          n_fail++; $display("FAIL %s chk_sum got %h exp %h", tag, chk_sum, exp_sum);
        end
        n_checks++;
        if (chk_ok !== !corrupt) begin
          n_fail++; $display("FAIL %s chk_ok got %b exp %b", tag, chk_ok, !corrupt);
        end
        n_checks++;
        if ({err, busy} !== 2'b01) begin
          n_fail++; $display("FAIL %s err/busy at done got %b exp 01", tag, {err, busy});
        end
      end else begin
        if (poke_start) begin
          start = (cyc == 3);
          base_addr = 7'($urandom);
          len = 8'($urandom);
        end
        s_valid = (idx < int'(l)) && (!gaps || $urandom_range(0, 2) != 0);
        s_data = s_valid ? bytes_q[idx] : 8'($urandom);
        if (s_valid && s_ready) idx++;
        @(negedge mclk);
        cyc++;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL %s timeout got no done exp done within 3000 cycles", tag);
    end
    @(negedge mclk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL %s done/busy after fin got %b exp 00", tag, {done, busy});
    end
    n_checks++;
    if (act_q.size() - n0 != nw) begin
      n_fail++; $display("FAIL %s write count got %0d exp %0d", tag, act_q.size() - n0, nw);
    end
    n_checks++;
    if (acc_cnt - a0 != 2 * nw) begin
      n_fail++; $display("FAIL %s access count got %0d exp %0d", tag, acc_cnt - a0, 2 * nw);
    end
    for (int w = 0; w < nw && n0 + w < act_q.size(); w++) begin
      n_checks++;
      if (act_q[n0 + w] !== exp_q[w]) begin
        n_fail++;
        $display("FAIL %s write %0d {addr,wenb,din} got %h exp %h", tag, w, act_q[n0 + w], exp_q[w]);
      end
    end
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s ram image got %0d bad words exp 0", tag, bad);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset();
    puc_rst = 1'b1;
    fill = 1'b1;
    repeat (2) @(negedge mclk);
    fill = 1'b0;
    puc_rst = 1'b0;
    n_checks++;
    if ({s_ready, ram_cenb, ram_wenb, busy, done, err, chk_ok} !== 8'b0111_0000) begin
      n_fail++;
      $display("FAIL reset flags got %b exp 01110000", {s_ready, ram_cenb, ram_wenb, busy, done, err, chk_ok});
    end
    n_checks++;
    if ({ram_addrb, ram_dinb, chk_sum} !== 39'd0) begin
      n_fail++; $display("FAIL reset buses got %h/%h/%h exp 0", ram_addrb, ram_dinb, chk_sum);
    end
  endtask

  task automatic test_basic();
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(7'h10, 8'd4, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_odd_len();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC};
    run_load(7'h20, 8'd3, 1'b0, 1'b0, 1'b0, "odd_len");
  endtask

  task automatic test_err();
    int a0;
    a0 = acc_cnt;
    @(negedge mclk);
    start = 1'b1; base_addr = 7'h7F; len = 8'd4;
    @(negedge mclk);
    start = 1'b0;
    n_checks++;
    if ({done, err, busy} !== 3'b111) begin
      n_fail++; $display("FAIL err done/err/busy got %b exp 111", {done, err, busy});
    end
    repeat (2) @(negedge mclk);
    n_checks++;
    if ({done, err, busy, ram_cenb} !== 4'b0101) begin
      n_fail++; $display("FAIL err hold done/err/busy/cenb got %b exp 0101", {done, err, busy, ram_cenb});
    end
    n_checks++;
    if (acc_cnt != a0) begin
      n_fail++; $display("FAIL err ram access got %0d exp 0", acc_cnt - a0);
    end
  endtask

  task automatic test_len0();
    int a0;
    a0 = acc_cnt;
    @(negedge mclk);
    start = 1'b1; base_addr = 7'($urandom); len = 8'd0;
    @(negedge mclk);
    start = 1'b0;
    n_checks++;
    if ({done, chk_ok, err} !== 3'b110) begin
      n_fail++; $display("FAIL len0 done/chk_ok/err got %b exp 110", {done, chk_ok, err});
    end
    n_checks++;
    if (chk_sum !== 16'h0000) begin
      n_fail++; $display("FAIL len0 chk_sum got %h exp 0000", chk_sum);
    end
    @(negedge mclk);
    n_checks++;
    if (acc_cnt != a0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0 accesses/busy got %0d/%b exp 0/0", acc_cnt - a0, busy);
    end
  endtask

  task automatic test_busy_start();
    bytes_q.delete();
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
    run_load(7'h40, 8'd8, 1'b0, 1'b0, 1'b1, "busy_start");
  endtask

  task automatic test_boundary();
    bytes_q.delete();
    for (int i = 0; i < 4; i++) bytes_q.push_back(8'($urandom));
    run_load(7'h7E, 8'd4, 1'b1, 1'b0, 1'b0, "bound_7e_4");
    run_load(7'h7F, 8'd2, 1'b0, 1'b0, 1'b0, "bound_7f_2");
    run_load(7'h7F, 8'd1, 1'b0, 1'b0, 1'b0, "bound_7f_1");
  endtask

  task automatic test_random();
    int l;
    for (int k = 0; k < 6; k++) begin
      l = $urandom_range(1, 40);
      bytes_q.delete();
      for (int i = 0; i < l; i++) bytes_q.push_back(8'($urandom));
      run_load(7'($urandom_range(0, (MEM_SIZE - l) / 2)), 8'(l), 1'b1, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_corrupt();
    bytes_q.delete();
    for (int i = 0; i < 11; i++) bytes_q.push_back(8'($urandom));
    run_load(7'h05, 8'd11, 1'b1, 1'b1, 1'b0, "corrupt");
  endtask

  task automatic test_reset_mid_load();
    int a1;
    bytes_q.delete();
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
    @(negedge mclk);
    start = 1'b1; base_addr = 7'h30; len = 8'd8;
    @(negedge mclk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = bytes_q[i];
      @(negedge mclk);
    end
    s_valid = 1'b0;
    puc_rst = 1'b1;
    @(negedge mclk);
    puc_rst = 1'b0;
    a1 = acc_cnt;
    n_checks++;
    if ({s_ready, ram_cenb, ram_wenb, busy, done, err, chk_ok} !== 8'b0111_0000) begin
      n_fail++;
      $display("FAIL midrst flags got %b exp 01110000", {s_ready, ram_cenb, ram_wenb, busy, done, err, chk_ok});
    end
    n_checks++;
    if ({ram_addrb, ram_dinb, chk_sum} !== 39'd0) begin
      n_fail++; $display("FAIL midrst buses got %h/%h/%h exp 0", ram_addrb, ram_dinb, chk_sum);
    end
    @(negedge mclk);
    n_checks++;
    if (acc_cnt != a1) begin
      n_fail++; $display("FAIL midrst access after reset got %0d exp 0", acc_cnt - a1);
    end
    run_load(7'h30, 8'd8, 1'b1, 1'b0, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_len();
    test_err();
    test_len0();
    test_busy_start();
    test_boundary();
    test_random();
    test_corrupt();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
